// File: rtl/regs_wr_arb.sv
// Two-port write arbiter for the picoMIPS register file: A has priority, B is forced after STARVE_MAX losses.
// Optional macro REGS_WR_ARB_FWD_EN adds combinational read forwarding from the registered write stage.
module regs_wr_arb #(
  parameter int unsigned n            = 8,
  parameter int unsigned STARVE_MAX   = 3,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall,
  input  logic         wa_valid,
  input  logic [1:0]   wa_addr,
  input  logic [n-1:0] wa_data,
  output logic         wa_ready,
  input  logic         wb_valid,
  input  logic [1:0]   wb_addr,
  input  logic [n-1:0] wb_data,
  output logic         wb_ready,
  output logic         w,
  output logic [1:0]   Waddr1,
  output logic [n-1:0] Wdata,
  output logic [3:0]   starve_cnt
`ifdef REGS_WR_ARB_FWD_EN
  ,
  input  logic [1:0]   fwd_raddr1,
  input  logic [7:0]   fwd_rdata1_in,
  input  logic [7:0]   fwd_raddr2,
  input  logic [n-1:0] fwd_rdata2_in,
  output logic [7:0]   fwd_rdata1_out,
  output logic [n-1:0] fwd_rdata2_out
`endif
);

  localparam int unsigned AW = 2;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic          w_q, w_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [n-1:0]  wdata_q, wdata_d;
  logic [CW-1:0] starve_q, starve_d;

  logic          gnt_a, gnt_b, issue;
  logic [AW-1:0] gnt_addr;
  logic [n-1:0]  gnt_data;

  // Grant: B wins when alone or when it has lost STARVE_MAX times in a row
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset_n && !stall) begin
      if (wb_valid && (!wa_valid || starve_q >= STARVE_LIM)) gnt_b = 1'b1;
      else if (wa_valid)                                      gnt_a = 1'b1;
    end
  end

  assign wa_ready = gnt_a;
  assign wb_ready = gnt_b;

  // Next-state for the write stage and the starvation counter
  always_comb begin
    gnt_addr = gnt_b ? wb_addr : wa_addr;
    gnt_data = gnt_b ? wb_data : wa_data;
    issue    = (gnt_a || gnt_b) && !(ZERO_PROTECT && gnt_addr == '0);
    w_d      = issue;
    waddr_d  = issue ? gnt_addr : waddr_q;
    wdata_d  = issue ? gnt_data : wdata_q;
    starve_d = starve_q;
    if (!stall) begin
      if (!wb_valid || gnt_b)                  starve_d = '0;
      else if (gnt_a && starve_q < STARVE_LIM) starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_q      <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      w_q      <= w_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  assign w          = w_q;
  assign Waddr1     = waddr_q;
  assign Wdata      = wdata_q;
  assign starve_cnt = starve_q;

`ifdef REGS_WR_ARB_FWD_EN
  logic fwd_ok, fwd_hit1, fwd_hit2;

  // Bypass the value being written this cycle; %0 is never forwarded when protected
  assign fwd_ok         = w_q && !(ZERO_PROTECT && waddr_q == '0);
  assign fwd_hit1       = fwd_ok && (fwd_raddr1 == waddr_q);
  assign fwd_hit2       = fwd_ok && (fwd_raddr2 == 8'(waddr_q));
  assign fwd_rdata1_out = fwd_hit1 ? 8'(wdata_q) : fwd_rdata1_in;
  assign fwd_rdata2_out = fwd_hit2 ? wdata_q : fwd_rdata2_in;
`endif

endmodule

// File: tb/tb_regs_wr_arb.sv
// Directed self-checking bench for regs_wr_arb (default parameters, optional forwarding under REGS_WR_ARB_FWD_EN).
module tb_regs_wr_arb;

  logic       clk = 1'b0;
  logic       reset_n, stall;
  logic       wa_valid, wb_valid;
  logic [1:0] wa_addr, wb_addr;
  logic [7:0] wa_data, wb_data;
  logic       wa_ready, wb_ready, w;
  logic [1:0] Waddr1;
  logic [7:0] Wdata;
  logic [3:0] starve_cnt;
`ifdef REGS_WR_ARB_FWD_EN
  logic [1:0] fwd_raddr1;
  logic [7:0] fwd_rdata1_in, fwd_raddr2, fwd_rdata2_in, fwd_rdata1_out, fwd_rdata2_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regs_wr_arb dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .wa_valid(wa_valid), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ready(wa_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .w(w), .Waddr1(Waddr1), .Wdata(Wdata), .starve_cnt(starve_cnt)
`ifdef REGS_WR_ARB_FWD_EN
    , .fwd_raddr1(fwd_raddr1), .fwd_rdata1_in(fwd_rdata1_in),
    .fwd_raddr2(fwd_raddr2), .fwd_rdata2_in(fwd_rdata2_in),
    .fwd_rdata1_out(fwd_rdata1_out), .fwd_rdata2_out(fwd_rdata2_out)
`endif
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_valid = 1'b0; wb_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle();
    wa_addr = 2'd0; wa_data = 8'h00; wb_addr = 2'd0; wb_data = 8'h00;
    step(); step();
    checks++;
    if (w !== 1'b0 || Wdata !== 8'h00 || Waddr1 !== 2'd0 || starve_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_state: got w=%b addr=%0d data=%h cnt=%0d expected 0/0/00/0", w, Waddr1, Wdata, starve_cnt);
    end
    wa_valid = 1'b1; #1;
    checks++;
    if (wa_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_reset: got %b expected 0", wa_ready);
    end
    // Accept a write, then reset during the issue cycle
    reset_n = 1'b1; wa_addr = 2'd2; wa_data = 8'h5A; #1;
    checks++;
    if (wa_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_accept: got %b expected 1", wa_ready);
    end
    step();
    checks++;
    if (w !== 1'b1 || Wdata !== 8'h5A) begin
      errors++; $display("FAIL reset_mid_issue: got w=%b data=%h expected 1/5a", w, Wdata);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (w !== 1'b0 || Wdata !== 8'h00 || starve_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_mid_write: got w=%b data=%h cnt=%0d expected 0/00/0", w, Wdata, starve_cnt);
    end
    reset_n = 1'b1; idle();
    step();
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL reset_no_write: got w=%b expected 0", w);
    end
  endtask

  task automatic test_single_a();
    wa_valid = 1'b1; wa_addr = 2'd1; wa_data = 8'h3C; #1;
    checks++;
    if (wa_ready !== 1'b1 || wb_ready !== 1'b0) begin
      errors++; $display("FAIL single_a_ready: got a=%b b=%b expected 1/0", wa_ready, wb_ready);
    end
    step();
    wa_valid = 1'b0;
    checks++;
    if (w !== 1'b1 || Waddr1 !== 2'd1 || Wdata !== 8'h3C) begin
      errors++; $display("FAIL single_a_issue: got w=%b addr=%0d data=%h expected 1/1/3c", w, Waddr1, Wdata);
    end
    step();
    checks++;
    if (w !== 1'b0 || Waddr1 !== 2'd1 || Wdata !== 8'h3C) begin
      errors++; $display("FAIL single_a_hold: got w=%b addr=%0d data=%h expected 0/1/3c", w, Waddr1, Wdata);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_cnt [4];
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd0};
    wa_valid = 1'b1; wa_addr = 2'd1; wa_data = 8'h11;
    wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (wa_ready !== (i < 3) || wb_ready !== (i == 3)) begin
        errors++; $display("FAIL contention_grant[%0d]: got a=%b b=%b expected %b/%b", i, wa_ready, wb_ready, i < 3, i == 3);
      end
      step();
      checks++;
      if (starve_cnt !== exp_cnt[i]) begin
        errors++; $display("FAIL contention_cnt[%0d]: got %0d expected %0d", i, starve_cnt, exp_cnt[i]);
      end
    end
    checks++;
    if (w !== 1'b1 || Waddr1 !== 2'd3 || Wdata !== 8'hA5) begin
      errors++; $display("FAIL contention_b_write: got w=%b addr=%0d data=%h expected 1/3/a5", w, Waddr1, Wdata);
    end
    idle(); step();
  endtask

  task automatic test_zero_protect();
    wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 8'hFF; #1;
    checks++;
    if (wb_ready !== 1'b1) begin
      errors++; $display("FAIL zero_ready: got %b expected 1", wb_ready);
    end
    step();
    wb_valid = 1'b0;
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL zero_suppress: got w=%b expected 0", w);
    end
    wa_valid = 1'b1; wa_addr = 2'd2; wa_data = 8'h42;
    step();
    wa_valid = 1'b0;
    checks++;
    if (w !== 1'b1 || Waddr1 !== 2'd2 || Wdata !== 8'h42) begin
      errors++; $display("FAIL zero_then_a: got w=%b addr=%0d data=%h expected 1/2/42", w, Waddr1, Wdata);
    end
    step();
  endtask

  task automatic test_stall();
    wa_valid = 1'b1; wa_addr = 2'd1; wa_data = 8'h01;
    wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 8'h02;
    step(); step();
    checks++;
    if (starve_cnt !== 4'd2) begin
      errors++; $display("FAIL stall_precount: got %0d expected 2", starve_cnt);
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (wa_ready !== 1'b0 || wb_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready[%0d]: got a=%b b=%b expected 0/0", i, wa_ready, wb_ready);
      end
      step();
      checks++;
      if (w !== 1'b0 || starve_cnt !== 4'd2) begin
        errors++; $display("FAIL stall_hold[%0d]: got w=%b cnt=%0d expected 0/2", i, w, starve_cnt);
      end
    end
    stall = 1'b0; #1;
    checks++;
    if (wa_ready !== 1'b1) begin
      errors++; $display("FAIL stall_resume_a: got %b expected 1", wa_ready);
    end
    step();
    checks++;
    if (starve_cnt !== 4'd3 || wb_ready !== 1'b1) begin
      errors++; $display("FAIL stall_resume_b: got cnt=%0d b=%b expected 3/1", starve_cnt, wb_ready);
    end
    step();
    checks++;
    if (starve_cnt !== 4'd0 || Wdata !== 8'h02 || w !== 1'b1) begin
      errors++; $display("FAIL stall_forced_b: got cnt=%0d data=%h w=%b expected 0/02/1", starve_cnt, Wdata, w);
    end
    idle(); step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] addrs [3];
    logic [7:0] datas [3];
    addrs = '{2'd1, 2'd2, 2'd3};
    datas = '{8'hC1, 8'hC2, 8'hC3};
    wa_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wa_addr = addrs[i]; wa_data = datas[i];
      step();
      checks++;
      if (w !== 1'b1 || Waddr1 !== addrs[i] || Wdata !== datas[i]) begin
        errors++; $display("FAIL back_to_back[%0d]: got w=%b addr=%0d data=%h expected 1/%0d/%h", i, w, Waddr1, Wdata, addrs[i], datas[i]);
      end
    end
    idle(); step();
  endtask

  task automatic test_same_addr();
    wa_valid = 1'b1; wa_addr = 2'd3; wa_data = 8'h10;
    wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 8'h20;
    step();
    checks++;
    if (Wdata !== 8'h10 || w !== 1'b1) begin
      errors++; $display("FAIL same_addr_a: got w=%b data=%h expected 1/10", w, Wdata);
    end
    wa_valid = 1'b0;
    step();
    checks++;
    if (Wdata !== 8'h20 || Waddr1 !== 2'd3 || w !== 1'b1) begin
      errors++; $display("FAIL same_addr_b: got w=%b addr=%0d data=%h expected 1/3/20", w, Waddr1, Wdata);
    end
    idle(); step();
  endtask

`ifdef REGS_WR_ARB_FWD_EN
  task automatic test_forward();
    fwd_raddr1 = 2'd2; fwd_rdata1_in = 8'h00; fwd_raddr2 = 8'd1; fwd_rdata2_in = 8'h99;
    wa_valid = 1'b1; wa_addr = 2'd2; wa_data = 8'h77;
    step();
    wa_valid = 1'b0; #1;
    checks++;
    if (fwd_rdata1_out !== 8'h77 || fwd_rdata2_out !== 8'h99) begin
      errors++; $display("FAIL forward_hit: got p1=%h p2=%h expected 77/99", fwd_rdata1_out, fwd_rdata2_out);
    end
    step();
    checks++;
    if (fwd_rdata1_out !== 8'h00) begin
      errors++; $display("FAIL forward_idle: got %h expected 00", fwd_rdata1_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_zero_protect();
    test_stall();
    test_back_to_back();
    test_same_addr();
`ifdef REGS_WR_ARB_FWD_EN
    test_forward();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
